parking_space_arbiter: RTL and testbench

//  Owns the two floor free-space counters of the parking controller and arbitrates the

---
 rtl/parking_pkg.sv | 43 ++++
 rtl/floor_counter.sv | 59 +++++
 rtl/parking_space_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_parking_space_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : parking_pkg                                                  |
// | Description : Shared definitions for the parking space arbiter: response   |
// |               codes, FSM state encoding, requester identifiers and default |
// |               floor capacities.                                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package parking_pkg;

    // Default geometry of the car park
    localparam int c_DEF_CNT_W    = 3;
    localparam int c_DEF_FLR0_CAP = 5;
    localparam int c_DEF_FLR1_CAP = 5;
    localparam int c_DEF_FLR0_RSV = 2;

    // Response codes presented on resp_code alongside an ack
    localparam logic [2:0] c_RESP_NONE         = 3'd0;
    localparam logic [2:0] c_RESP_GRANT_CHOSEN = 3'd1;
    localparam logic [2:0] c_RESP_GRANT_ALT    = 3'd2;
    localparam logic [2:0] c_RESP_NO_SPACE     = 3'd3;
    localparam logic [2:0] c_RESP_EXIT_OK      = 3'd4;
    localparam logic [2:0] c_RESP_EXIT_ERR     = 3'd5;
    localparam logic [2:0] c_RESP_ADMIN_OK     = 3'd6;
    localparam logic [2:0] c_RESP_ADMIN_ERR    = 3'd7;

    // Transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECIDE = 2'd1,
        ST_ACK    = 2'd2
    } state_e;

    // Requester currently owning the transaction
    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_ENTRY = 2'd1,
        REQ_EXIT  = 2'd2,
        REQ_ADMIN = 2'd3
    } req_id_e;

endpackage
`default_nettype wire

// File: rtl/floor_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : floor_counter                                                |
// | Description : Free-space counter for one floor. Supports decrement,        |
// |               increment and load, never wraps and never exceeds CAP.       |
// |   clk, reset      : clock, synchronous active-high reset (count <= CAP)    |
// |   dec/inc/load    : update strobes (load > dec > inc if several are set)   |
// |   load_val        : value for load, ignored when above CAP                 |
// |   thresh          : compare value for can_dec_above                        |
// |   count           : registered free count                                  |
// |   count_nxt       : value count takes at the next edge                     |
// |   can_dec_above   : count > thresh                                         |
// |   full            : count == CAP (no car parked on this floor)             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module floor_counter #(
    parameter int CNT_W = 3,
    parameter int CAP   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec,
    input  logic             inc,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             can_dec_above,
    output logic             full
);

    localparam logic [CNT_W-1:0] c_CAP = CNT_W'(CAP);

    logic [CNT_W-1:0] r_count;

    // Each strobe is guarded so a misbehaving caller can never wrap the count
    always_comb begin
        count_nxt = r_count;
        if (load) begin
            if (load_val <= c_CAP) count_nxt = load_val;
        end else if (dec) begin
            if (r_count != '0) count_nxt = r_count - 1'b1;
        end else if (inc) begin
            if (r_count < c_CAP) count_nxt = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_count <= c_CAP;
        else       r_count <= count_nxt;
    end

    assign count         = r_count;
    assign can_dec_above = (r_count > thresh);
    assign full          = (r_count == c_CAP);

endmodule
`default_nettype wire

// File: rtl/parking_space_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : parking_space_arbiter                                        |
// | Description : Owns both floor free counters and serialises entry, exit and |
// |               admin requests (admin > exit > entry). Each transaction runs |
// |               IDLE -> DECIDE -> ACK and ends with a one-cycle ack carrying |
// |               resp_code / resp_flr.                                        |
// |   entry_req/flr/special : car entry request                                |
// |   exit_req/flr          : car exit request                                 |
// |   admin_req/flr/cnt     : load a floor's free count                        |
// |   *_ack                 : completion pulse for the winning requester       |
// |   resp_code, resp_flr   : result, valid with an ack                        |
// |   busy                  : transaction in progress                          |
// |   flr0/1_free, tot_free : registered occupancy                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module parking_space_arbiter
    import parking_pkg::*;
#(
    parameter int CNT_W    = c_DEF_CNT_W,
    parameter int FLR0_CAP = c_DEF_FLR0_CAP,
    parameter int FLR1_CAP = c_DEF_FLR1_CAP,
    parameter int FLR0_RSV = c_DEF_FLR0_RSV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             entry_flr,
    input  logic             entry_special,
    input  logic             exit_req,
    input  logic             exit_flr,
    input  logic             admin_req,
    input  logic             admin_flr,
    input  logic [CNT_W-1:0] admin_cnt,
    output logic             entry_ack,
    output logic             exit_ack,
    output logic             admin_ack,
    output logic [2:0]       resp_code,
    output logic             resp_flr,
    output logic             busy,
    output logic [CNT_W-1:0] flr0_free,
    output logic [CNT_W-1:0] flr1_free,
    output logic [CNT_W:0]   tot_free
);

    localparam logic [CNT_W-1:0] c_CAP0 = CNT_W'(FLR0_CAP);
    localparam logic [CNT_W-1:0] c_CAP1 = CNT_W'(FLR1_CAP);
    localparam logic [CNT_W-1:0] c_RSV0 = CNT_W'(FLR0_RSV);
    localparam logic [CNT_W:0]   c_TOT  = (CNT_W+1)'(FLR0_CAP + FLR1_CAP);

    state_e           r_state, w_state_nxt;
    req_id_e          r_winner, w_winner;
    logic             r_flr;
    logic             r_special;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_resp_code, w_code;
    logic             r_resp_flr, w_rflr;
    logic [CNT_W:0]   r_tot;

    logic             w_any_req;
    logic             w_pref;
    logic [1:0]       w_dec, w_inc, w_load;
    logic [1:0]       w_ok, w_full;
    logic [CNT_W-1:0] w_thresh0;
    logic [CNT_W-1:0] w_nxt0, w_nxt1;

    // ---------------- Fixed-priority request selection ----------------
    assign w_any_req = admin_req | exit_req | entry_req;

    always_comb begin
        w_winner = REQ_NONE;
        if (admin_req)      w_winner = REQ_ADMIN;
        else if (exit_req)  w_winner = REQ_EXIT;
        else if (entry_req) w_winner = REQ_ENTRY;
    end

    // ---------------- Floor counters ----------------
    // Regular IDs may only take floor 0 while more than the reserved spaces remain
    assign w_thresh0 = r_special ? '0 : c_RSV0;

    floor_counter #(.CNT_W(CNT_W), .CAP(FLR0_CAP)) u_flr0 (
        .clk           (clk),
        .reset         (reset),
        .dec           (w_dec[0]),
        .inc           (w_inc[0]),
        .load          (w_load[0]),
        .load_val      (r_cnt),
        .thresh        (w_thresh0),
        .count         (flr0_free),
        .count_nxt     (w_nxt0),
        .can_dec_above (w_ok[0]),
        .full          (w_full[0])
    );

    floor_counter #(.CNT_W(CNT_W), .CAP(FLR1_CAP)) u_flr1 (
        .clk           (clk),
        .reset         (reset),
        .dec           (w_dec[1]),
        .inc           (w_inc[1]),
        .load          (w_load[1]),
        .load_val      (r_cnt),
        .thresh        ('0),
        .count         (flr1_free),
        .count_nxt     (w_nxt1),
        .can_dec_above (w_ok[1]),
        .full          (w_full[1])
    );

    // ---------------- Next state and allocation decision ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_code      = c_RESP_NONE;
        w_rflr      = 1'b0;
        w_dec       = 2'b00;
        w_inc       = 2'b00;
        w_load      = 2'b00;
        // Special IDs always try floor 0 first; regular IDs try the floor asked for
        w_pref      = r_special ? 1'b0 : r_flr;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) w_state_nxt = ST_DECIDE;
            end
            ST_DECIDE: begin
                w_state_nxt = ST_ACK;
                case (r_winner)
                    REQ_ENTRY: begin
                        if (w_ok[w_pref]) begin
                            w_dec[w_pref] = 1'b1;
                            w_rflr        = w_pref;
                            w_code        = (w_pref == r_flr) ? c_RESP_GRANT_CHOSEN
                                                              : c_RESP_GRANT_ALT;
                        end else if (w_ok[~w_pref]) begin
                            w_dec[~w_pref] = 1'b1;
                            w_rflr         = ~w_pref;
                            w_code         = (~w_pref == r_flr) ? c_RESP_GRANT_CHOSEN
                                                                : c_RESP_GRANT_ALT;
                        end else begin
                            w_rflr = r_flr;
                            w_code = c_RESP_NO_SPACE;
                        end
                    end
                    REQ_EXIT: begin
                        w_rflr = r_flr;
                        if (w_full[r_flr]) begin
                            w_code = c_RESP_EXIT_ERR;
                        end else begin
                            w_inc[r_flr] = 1'b1;
                            w_code       = c_RESP_EXIT_OK;
                        end
                    end
                    REQ_ADMIN: begin
                        w_rflr = r_flr;
                        if (r_cnt <= (r_flr ? c_CAP1 : c_CAP0)) begin
                            w_load[r_flr] = 1'b1;
                            w_code        = c_RESP_ADMIN_OK;
                        end else begin
                            w_code = c_RESP_ADMIN_ERR;
                        end
                    end
                    default: ;
                endcase
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_winner    <= REQ_NONE;
            r_flr       <= 1'b0;
            r_special   <= 1'b0;
            r_cnt       <= '0;
            r_resp_code <= c_RESP_NONE;
            r_resp_flr  <= 1'b0;
            r_tot       <= c_TOT;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_any_req) begin
                r_winner  <= w_winner;
                r_flr     <= admin_req ? admin_flr : (exit_req ? exit_flr : entry_flr);
                r_special <= entry_special;
                r_cnt     <= admin_cnt;
            end
            if (r_state == ST_DECIDE) begin
                r_resp_code <= w_code;
                r_resp_flr  <= w_rflr;
            end
            // Tracks the counters' next values so the total moves on the same edge
            r_tot <= {1'b0, w_nxt0} + {1'b0, w_nxt1};
        end
    end

    // ---------------- Outputs ----------------
    assign entry_ack = (r_state == ST_ACK) && (r_winner == REQ_ENTRY);
    assign exit_ack  = (r_state == ST_ACK) && (r_winner == REQ_EXIT);
    assign admin_ack = (r_state == ST_ACK) && (r_winner == REQ_ADMIN);
    assign resp_code = r_resp_code;
    assign resp_flr  = r_resp_flr;
    assign busy      = (r_state != ST_IDLE);
    assign tot_free  = r_tot;

endmodule
`default_nettype wire

// File: tb/tb_parking_space_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_parking_space_arbiter                                     |
// | Description : Scoreboard bench for parking_space_arbiter. Drivers push the |
// |               reference model's expected reply; a monitor pops and checks  |
// |               on every ack.                                                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_parking_space_arbiter;

    localparam int c_RSV = 2;
    localparam int c_KIND_ENTRY = 0;
    localparam int c_KIND_EXIT  = 1;
    localparam int c_KIND_ADMIN = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       entry_req = 1'b0, entry_flr = 1'b0, entry_special = 1'b0;
    logic       exit_req = 1'b0, exit_flr = 1'b0;
    logic       admin_req = 1'b0, admin_flr = 1'b0;
    logic [2:0] admin_cnt = 3'd0;
    logic       entry_ack, exit_ack, admin_ack;
    logic [2:0] resp_code;
    logic       resp_flr, busy;
    logic [2:0] flr0_free, flr1_free;
    logic [3:0] tot_free;

    parking_space_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .entry_req     (entry_req),
        .entry_flr     (entry_flr),
        .entry_special (entry_special),
        .exit_req      (exit_req),
        .exit_flr      (exit_flr),
        .admin_req     (admin_req),
        .admin_flr     (admin_flr),
        .admin_cnt     (admin_cnt),
        .entry_ack     (entry_ack),
        .exit_ack      (exit_ack),
        .admin_ack     (admin_ack),
        .resp_code     (resp_code),
        .resp_flr      (resp_flr),
        .busy          (busy),
        .flr0_free     (flr0_free),
        .flr1_free     (flr1_free),
        .tot_free      (tot_free)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;
        int code;
        int flr;
        int f0;
        int f1;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_free[2];
    int   m_cap[2];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int thr(input int f, input int spec);
        return (f == 0 && spec == 0) ? c_RSV : 0;
    endfunction

    // Reference model: applies one transaction to the free-space array
    function automatic exp_t model(input int kind, input int flr, input int spec, input int cnt);
        exp_t e;
        int first, second, take;
        e.kind = kind;
        e.flr  = flr;
        if (kind == c_KIND_ENTRY) begin
            first  = (spec != 0) ? 0 : flr;
            second = 1 - first;
            if (m_free[first] > thr(first, spec))        take = first;
            else if (m_free[second] > thr(second, spec)) take = second;
            else                                         take = -1;
            if (take < 0) begin
                e.code = 3;
            end else begin
                m_free[take]--;
                e.code = (take == flr) ? 1 : 2;
                e.flr  = take;
            end
        end else if (kind == c_KIND_EXIT) begin
            if (m_free[flr] < m_cap[flr]) begin
                m_free[flr]++;
                e.code = 4;
            end else begin
                e.code = 5;
            end
        end else begin
            if (cnt <= m_cap[flr]) begin
                m_free[flr] = cnt;
                e.code = 6;
            end else begin
                e.code = 7;
            end
        end
        e.f0 = m_free[0];
        e.f1 = m_free[1];
        return e;
    endfunction

    // Monitor: any ack pops the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        int nack, kind;
        if (!reset) begin
            nack = int'(entry_ack) + int'(exit_ack) + int'(admin_ack);
            if (nack > 1) chk("ack_onehot", nack, 1);
            if (nack != 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", nack, 0);
                end else begin
                    e = sb.pop_front();
                    kind = admin_ack ? c_KIND_ADMIN : (exit_ack ? c_KIND_EXIT : c_KIND_ENTRY);
                    chk("ack_kind", kind, e.kind);
                    chk("resp_code", int'(resp_code), e.code);
                    chk("resp_flr", int'(resp_flr), e.flr);
                    chk("flr0_free", int'(flr0_free), e.f0);
                    chk("flr1_free", int'(flr1_free), e.f1);
                    chk("tot_free", int'(tot_free), e.f0 + e.f1);
                end
            end
        end
    end

    function automatic logic ack_of(input int kind);
        return (kind == c_KIND_ENTRY) ? entry_ack : ((kind == c_KIND_EXIT) ? exit_ack : admin_ack);
    endfunction

    // One transaction at a time: raise request, wait for ack, drop request
    task automatic do_txn(input int kind, input int flr, input int spec, input int cnt);
        int n;
        bit got;
        sb.push_back(model(kind, flr, spec, cnt));
        @(negedge clk);
        case (kind)
            c_KIND_ENTRY: begin entry_req = 1'b1; entry_flr = flr[0]; entry_special = spec[0]; end
            c_KIND_EXIT:  begin exit_req = 1'b1; exit_flr = flr[0]; end
            default:      begin admin_req = 1'b1; admin_flr = flr[0]; admin_cnt = cnt[2:0]; end
        endcase
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (ack_of(kind)) got = 1'b1;
        end
        chk("latency", got ? n : -1, 2);
        entry_req = 1'b0;
        exit_req  = 1'b0;
        admin_req = 1'b0;
        if (!got) sb.delete();
    endtask

    initial begin
        int n, t_ad, t_ex, t_en;
        m_cap[0]  = 5;
        m_cap[1]  = 5;
        m_free[0] = 5;
        m_free[1] = 5;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_flr0", int'(flr0_free), 5);
        chk("rst_flr1", int'(flr1_free), 5);
        chk("rst_tot", int'(tot_free), 10);
        chk("rst_busy", int'(busy), 0);
        chk("rst_acks", int'(entry_ack) + int'(exit_ack) + int'(admin_ack), 0);
        chk("rst_code", int'(resp_code), 0);
        chk("rst_rflr", int'(resp_flr), 0);

        // Five regular entries on floor 0: three chosen, then two spill to floor 1
        for (int i = 0; i < 5; i++) do_txn(c_KIND_ENTRY, 0, 0, 0);
        chk("t1_flr0", int'(flr0_free), 2);
        chk("t1_flr1", int'(flr1_free), 3);

        // Park full: no space
        do_txn(c_KIND_ADMIN, 0, 0, 0);
        do_txn(c_KIND_ADMIN, 1, 0, 0);
        do_txn(c_KIND_ENTRY, 1, 0, 0);

        // Only reserved spaces left on floor 0
        do_txn(c_KIND_ADMIN, 0, 0, 2);
        do_txn(c_KIND_ADMIN, 1, 0, 5);
        do_txn(c_KIND_ENTRY, 1, 1, 0);
        do_txn(c_KIND_ENTRY, 0, 0, 0);
        chk("t3_flr0", int'(flr0_free), 1);
        chk("t3_flr1", int'(flr1_free), 4);

        // Simultaneous admin/exit/entry: served in priority order, 3 cycles apart
        sb.push_back(model(c_KIND_ADMIN, 0, 0, 4));
        sb.push_back(model(c_KIND_EXIT, 0, 0, 0));
        sb.push_back(model(c_KIND_ENTRY, 1, 0, 0));
        @(negedge clk);
        admin_req = 1'b1; admin_flr = 1'b0; admin_cnt = 3'd4;
        exit_req  = 1'b1; exit_flr  = 1'b0;
        entry_req = 1'b1; entry_flr = 1'b1; entry_special = 1'b0;
        t_ad = -1; t_ex = -1; t_en = -1;
        n = 0;
        while (t_en < 0 && n < 30) begin
            @(negedge clk);
            n++;
            if (admin_ack) begin t_ad = n; admin_req = 1'b0; end
            if (exit_ack)  begin t_ex = n; exit_req  = 1'b0; end
            if (entry_ack) begin t_en = n; entry_req = 1'b0; end
        end
        admin_req = 1'b0; exit_req = 1'b0; entry_req = 1'b0;
        chk("t4_admin_cycle", t_ad, 2);
        chk("t4_exit_cycle", t_ex, 5);
        chk("t4_entry_cycle", t_en, 8);
        if (t_en < 0) sb.delete();

        // Exit/admin error and success paths
        do_txn(c_KIND_ADMIN, 1, 0, 5);
        do_txn(c_KIND_EXIT, 1, 0, 0);
        do_txn(c_KIND_ADMIN, 0, 0, 7);
        do_txn(c_KIND_ADMIN, 0, 0, 3);
        chk("t5_flr0", int'(flr0_free), 3);

        // Randomised traffic
        for (int i = 0; i < 150; i++)
            do_txn($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 7));

        // Reset during DECIDE discards the transaction
        do_txn(c_KIND_ADMIN, 0, 0, 1);
        @(negedge clk);
        entry_req = 1'b1; entry_flr = 1'b0; entry_special = 1'b0;
        @(negedge clk);
        chk("t6_busy_decide", int'(busy), 1);
        reset = 1'b1;
        entry_req = 1'b0;
        @(negedge clk);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ack", int'(entry_ack), 0);
        chk("t6_flr0", int'(flr0_free), 5);
        chk("t6_flr1", int'(flr1_free), 5);
        chk("t6_tot", int'(tot_free), 10);
        reset = 1'b0;
        m_free[0] = 5;
        m_free[1] = 5;
        repeat (5) @(negedge clk);
        chk("t6_sb_empty", sb.size(), 0);
        do_txn(c_KIND_ENTRY, 1, 0, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
